// File: rtl/ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control carrier: control-word
// bit positions and the packed records held at each stage boundary.
package ctrl_pkg;

    localparam int CW_W         = 9;
    localparam int CW_MEMTOREG  = 8;
    localparam int CW_REGWRITE  = 7;
    localparam int CW_BRANCH    = 6;
    localparam int CW_MEMREAD   = 5;
    localparam int CW_MEMWRITE  = 4;
    localparam int CW_REGDST    = 3;
    localparam int CW_ALUSRC    = 2;
    localparam int CW_ALUOP_R   = 1;
    localparam int CW_ALUOP_BEQ = 0;

    localparam logic [CW_W-1:0] BUBBLE = '0;

    typedef struct packed {
        logic [CW_W-1:0] ctrl;
        logic            bne;
        logic            imm;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
    } ex_rec_t;

    // MEM keeps only the WB and M groups of the control word (ctrl[8:4]).
    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       branch;
        logic       memread;
        logic       memwrite;
        logic       bne;
        logic [4:0] dest;
    } mem_rec_t;

    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] dest;
    } wb_rec_t;

    localparam ex_rec_t  EX_BUBBLE  = '0;
    localparam mem_rec_t MEM_BUBBLE = '0;
    localparam wb_rec_t  WB_BUBBLE  = '0;

    function automatic logic [4:0] sel_dest(input ex_rec_t r);
        return r.ctrl[CW_REGDST] ? r.rd : r.rt;
    endfunction

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Combinational load-use hazard detection and MEM-stage branch resolution.
module hazard_unit (
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       mem_branch,
    input  logic       mem_bne,
    input  logic       mem_zero,
    output logic       stall,
    output logic       flush_ifid,
    output logic       pc_src
);

    logic hz;

    // A load targeting $zero never produces a usable value, so it cannot hazard.
    assign hz         = ex_memread & (ex_rt != 5'd0) & ((ex_rt == id_rs) | (ex_rt == id_rt));
    assign pc_src     = (mem_branch & mem_zero) | (mem_bne & ~mem_zero);
    assign flush_ifid = pc_src;
    // A taken branch squashes the dependent instruction anyway, so flush wins.
    assign stall      = hz & ~pc_src;

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the ID control word through ID/EX, EX/MEM and MEM/WB, selects the
// write-back destination, and counts stall and flush events.
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CW_W-1:0]  id_ctrl,
    input  logic             id_bne,
    input  logic             id_imm,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             mem_zero,
    output logic             ex_regdst,
    output logic             ex_alusrc,
    output logic             ex_aluop_r,
    output logic             ex_aluop_beq,
    output logic             ex_imm,
    output logic [4:0]       ex_rs,
    output logic [4:0]       ex_rt,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_regwrite,
    output logic [4:0]       mem_dest,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [4:0]       wb_dest,
    output logic             stall,
    output logic             flush_ifid,
    output logic             pc_src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ex_rec_t          ex_q,  ex_d;
    mem_rec_t         mem_q, mem_d;
    wb_rec_t          wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    hazard_unit u_hazard (
        .ex_memread (ex_q.ctrl[CW_MEMREAD]),
        .ex_rt      (ex_q.rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .mem_branch (mem_q.branch),
        .mem_bne    (mem_q.bne),
        .mem_zero   (mem_zero),
        .stall      (stall),
        .flush_ifid (flush_ifid),
        .pc_src     (pc_src)
    );

    // NOTE: every always_comb target gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        wb_d.memtoreg = mem_q.memtoreg;
        wb_d.regwrite = mem_q.regwrite;
        wb_d.dest     = mem_q.dest;

        if (pc_src) begin
            ex_d  = EX_BUBBLE;
            mem_d = MEM_BUBBLE;
        end else begin
            mem_d.memtoreg = ex_q.ctrl[CW_MEMTOREG];
            mem_d.regwrite = ex_q.ctrl[CW_REGWRITE];
            mem_d.branch   = ex_q.ctrl[CW_BRANCH];
            mem_d.memread  = ex_q.ctrl[CW_MEMREAD];
            mem_d.memwrite = ex_q.ctrl[CW_MEMWRITE];
            mem_d.bne      = ex_q.bne;
            mem_d.dest     = sel_dest(ex_q);
            if (stall) begin
                ex_d = EX_BUBBLE;
            end else begin
                ex_d.ctrl = id_ctrl;
                ex_d.bne  = id_bne;
                ex_d.imm  = id_imm;
                ex_d.rs   = id_rs;
                ex_d.rt   = id_rt;
                ex_d.rd   = id_rd;
            end
        end

        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (pc_src && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples the pre-edge value of its upstream neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q        <= EX_BUBBLE;
            mem_q       <= MEM_BUBBLE;
            wb_q        <= WB_BUBBLE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_regdst    = ex_q.ctrl[CW_REGDST];
    assign ex_alusrc    = ex_q.ctrl[CW_ALUSRC];
    assign ex_aluop_r   = ex_q.ctrl[CW_ALUOP_R];
    assign ex_aluop_beq = ex_q.ctrl[CW_ALUOP_BEQ];
    assign ex_imm       = ex_q.imm;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;

    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_regwrite = mem_q.regwrite;
    assign mem_dest     = mem_q.dest;

    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_dest      = wb_q.dest;

    assign stall_cnt    = stall_cnt_q;
    assign flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Randomized and directed bench for ctrl_pipe against an instruction-level model.
module tb_ctrl_pipe;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = 15;

    localparam logic [8:0] C_NOP = 9'b0_0_000_0000;
    localparam logic [8:0] C_RT  = 9'b0_1_000_1010;
    localparam logic [8:0] C_LW  = 9'b1_1_010_0100;
    localparam logic [8:0] C_BEQ = 9'b0_0_100_0001;
    localparam logic [8:0] C_BNE = 9'b0_0_000_0001;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [8:0]       id_ctrl = '0;
    logic             id_bne = 1'b0, id_imm = 1'b0, mem_zero = 1'b0;
    logic [4:0]       id_rs = '0, id_rt = '0, id_rd = '0;
    logic             ex_regdst, ex_alusrc, ex_aluop_r, ex_aluop_beq, ex_imm;
    logic [4:0]       ex_rs, ex_rt, mem_dest, wb_dest;
    logic             mem_memread, mem_memwrite, mem_regwrite, wb_memtoreg, wb_regwrite;
    logic             stall, flush_ifid, pc_src;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    ctrl_pipe #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_bne(id_bne), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_zero(mem_zero),
        .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop_r(ex_aluop_r),
        .ex_aluop_beq(ex_aluop_beq), .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .mem_regwrite(mem_regwrite),
        .mem_dest(mem_dest), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .wb_dest(wb_dest), .stall(stall), .flush_ifid(flush_ifid), .pc_src(pc_src),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Model: each stage slot holds the whole instruction as it left ID.
    typedef struct packed {
        logic [8:0] c;
        logic       bne;
        logic       imm;
        logic [4:0] rs, rt, rd;
    } ins_t;

    ins_t m_ex, m_mem, m_wb, n_ex, n_mem, n_wb;
    int   m_scnt, m_fcnt, n_scnt, n_fcnt;
    int   n_cmp = 0;
    int   n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] dest_of(input ins_t i);
        return i.c[3] ? i.rd : i.rt;
    endfunction

    function automatic logic [63:0] all_outs();
        return {ex_regdst, ex_alusrc, ex_aluop_r, ex_aluop_beq, ex_imm, ex_rs, ex_rt,
                mem_memread, mem_memwrite, mem_regwrite, mem_dest,
                wb_memtoreg, wb_regwrite, wb_dest, stall, flush_ifid, pc_src,
                stall_cnt, flush_cnt};
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_wb = '0;
        n_ex = '0; n_mem = '0; n_wb = '0;
        m_scnt = 0; m_fcnt = 0; n_scnt = 0; n_fcnt = 0;
    endtask

    // Compare every output with the model and prepare the post-edge state.
    task automatic check_model();
        ins_t id_i;
        logic hz, e_pc, e_stall;
        id_i    = '{c: id_ctrl, bne: id_bne, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd};
        hz      = m_ex.c[5] && (m_ex.rt != 0) && (m_ex.rt == id_rs || m_ex.rt == id_rt);
        e_pc    = (m_mem.c[6] && mem_zero) || (m_mem.bne && !mem_zero);
        e_stall = hz && !e_pc;

        check("ex", {ex_regdst, ex_alusrc, ex_aluop_r, ex_aluop_beq, ex_imm, ex_rs, ex_rt},
              {m_ex.c[3:0], m_ex.imm, m_ex.rs, m_ex.rt});
        check("mem", {mem_memread, mem_memwrite, mem_regwrite, mem_dest},
              {m_mem.c[5], m_mem.c[4], m_mem.c[7], dest_of(m_mem)});
        check("wb", {wb_memtoreg, wb_regwrite, wb_dest}, {m_wb.c[8], m_wb.c[7], dest_of(m_wb)});
        check("stall", stall, e_stall);
        check("flush_ifid", flush_ifid, e_pc);
        check("pc_src", pc_src, e_pc);
        check("stall_cnt", stall_cnt, m_scnt);
        check("flush_cnt", flush_cnt, m_fcnt);

        n_wb   = m_mem;
        n_mem  = e_pc ? '0 : m_ex;
        n_ex   = (e_pc || e_stall) ? '0 : id_i;
        n_scnt = (e_stall && m_scnt < CNT_MAX) ? m_scnt + 1 : m_scnt;
        n_fcnt = (e_pc && m_fcnt < CNT_MAX) ? m_fcnt + 1 : m_fcnt;
    endtask

    task automatic drive(input logic [8:0] c, input logic bne, input logic imm,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic zero);
        @(negedge clk);
        id_ctrl = c; id_bne = bne; id_imm = imm;
        id_rs = rs; id_rt = rt; id_rd = rd; mem_zero = zero;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        m_ex = n_ex; m_mem = n_mem; m_wb = n_wb;
        m_scnt = n_scnt; m_fcnt = n_fcnt;
    endtask

    task automatic nop_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive(C_NOP, 0, 0, 0, 0, 0, 0);
            tick();
        end
    endtask

    task automatic rand_cycle();
        drive(9'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 31)), 1'($urandom));
        tick();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_all_zero", all_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // R-type: regdst at EX, dest 5 at MEM, then WB.
        drive(C_RT, 0, 0, 1, 2, 5, 0); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0); check("rt_ex_regdst", ex_regdst, 1); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        check("rt_mem", {mem_regwrite, mem_dest}, {1'b1, 5'd5}); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        check("rt_wb", {wb_regwrite, wb_dest}, {1'b1, 5'd5}); tick();

        // lw rt=8 then a consumer of r8: one stall, then a bubble in EX.
        drive(C_LW, 0, 0, 1, 8, 0, 0); tick();
        drive(C_RT, 0, 0, 8, 3, 9, 0); check("lw_use_stall", stall, 1); tick();
        drive(C_RT, 0, 0, 8, 3, 9, 0);
        check("lw_stall_once", stall, 0);
        check("lw_ex_bubble", {ex_regdst, ex_aluop_r, ex_rs, ex_rt}, 12'd0);
        check("lw_stall_cnt", stall_cnt, 1);
        tick();
        nop_cycles(3);

        // lw into $zero never stalls.
        drive(C_LW, 0, 0, 1, 0, 0, 0); tick();
        drive(C_RT, 0, 0, 0, 0, 4, 0); check("zero_no_stall", stall, 0); tick();
        nop_cycles(3);

        // Taken beq in MEM squashes EX and MEM.
        drive(C_BEQ, 0, 0, 1, 2, 0, 0); tick();
        drive(C_RT, 0, 0, 3, 4, 7, 0); tick();
        drive(C_RT, 0, 0, 3, 4, 6, 1);
        check("beq_taken", {pc_src, flush_ifid}, 2'b11); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 1);
        check("beq_bubbles", {ex_regdst, mem_regwrite, mem_dest}, 7'd0);
        check("beq_flush_cnt", flush_cnt, 1);
        tick();
        nop_cycles(2);

        drive(C_BEQ, 0, 0, 1, 2, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0); check("beq_not_taken", pc_src, 0); tick();
        nop_cycles(2);

        // Taken bne in MEM while EX has a load-use hazard: flush wins.
        drive(C_BNE, 1, 0, 1, 2, 0, 0); tick();
        drive(C_LW, 0, 0, 1, 9, 0, 0); tick();
        drive(C_RT, 0, 0, 9, 3, 4, 0);
        check("bne_hz_flags", {stall, pc_src}, 2'b01); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        check("bne_hz_counts", {stall_cnt, flush_cnt}, {4'd1, 4'd2});
        tick();
        nop_cycles(2);

        // Drive the stall counter into saturation and one stall beyond.
        for (int i = 0; i < CNT_MAX; i++) begin
            drive(C_LW, 0, 0, 1, 8, 0, 0); tick();
            drive(C_RT, 0, 0, 8, 3, 9, 0); tick();
        end
        drive(C_NOP, 0, 0, 0, 0, 0, 0); check("stall_cnt_full", stall_cnt, CNT_MAX); tick();
        drive(C_LW, 0, 0, 1, 8, 0, 0); tick();
        drive(C_RT, 0, 0, 8, 3, 9, 0); check("sat_stall_seen", stall, 1); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0); check("stall_cnt_sat", stall_cnt, CNT_MAX); tick();

        for (int i = 0; i < 400; i++) rand_cycle();

        // Asynchronous reset mid-stream, then release with a zero ID word.
        drive(C_RT, 0, 1, 1, 2, 3, 0);
        #2;
        rst_n = 1'b0;
        id_ctrl = '0; id_bne = 0; id_imm = 0; id_rs = '0; id_rt = '0; id_rd = '0; mem_zero = 0;
        #1;
        check("midrst_all_zero", all_outs(), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive(C_NOP, 0, 0, 0, 0, 0, 0); tick();
        drive(C_NOP, 0, 0, 0, 0, 0, 0);
        check("post_rst_zero", all_outs(), 64'd0);
        tick();

        for (int i = 0; i < 300; i++) rand_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipeline control-word carrier for the five-stage MIPS core. It accepts the 9-bit packed control word and the bne/imm flags produced in ID, and registers them through the ID/EX, EX/MEM and MEM/WB boundaries. It unpacks the fields each stage consumes and selects the write-back destination register. It also detects load-use hazards, generating stall and bubble, and resolves taken branches in MEM, generating flush.

## Interface
- `CNT_W`, default 16: width of the saturating stall/flush event counters.
- `clk` input, 1: pipeline clock, rising edge.
- `rst_n` input, 1: asynchronous active-low reset.
- `id_ctrl` input, 9: packed control word:
  - [8] memtoreg, [7] regwrite (WB).
  - [6] branch, [5] memread, [4] memwrite (M).
  - [3] regdst, [2] alusrc, [1] aluop_r, [0] aluop_beq (EX).
- `id_bne` input, 1: decoded bne in ID.
- `id_imm` input, 1: decoded andi/ori/addi in ID.
- `id_rs`, `id_rt`, `id_rd` input, 5 each: register fields of the ID instruction.
- `mem_zero` input, 1: ALU zero flag of the instruction in MEM.
- `ex_regdst`, `ex_alusrc`, `ex_aluop_r`, `ex_aluop_beq`, `ex_imm` output, 1 each: EX-stage controls.
- `ex_rs`, `ex_rt` output, 5 each: EX-stage source registers, for forwarding.
- `mem_memread`, `mem_memwrite`, `mem_regwrite` output, 1 each: MEM-stage controls.
- `mem_dest` output, 5: MEM-stage destination register.
- `wb_memtoreg`, `wb_regwrite` output, 1 each: WB-stage controls.
- `wb_dest` output, 5: WB-stage destination register.
- `stall` output, 1: hold PC and IF/ID this cycle.
- `flush_ifid` output, 1: clear IF/ID this cycle.
- `pc_src` output, 1: branch taken in MEM; select the branch target.
- `stall_cnt`, `flush_cnt` output, `CNT_W` each: saturating event counters.

## Operation
- Stage registers:
  - EX holds {ctrl[8:0], bne, imm, rs, rt, rd}.
  - MEM holds {ctrl[8:4], bne, dest}.
  - WB holds {ctrl[8:7], dest}.
- Bubble: all control bits 0; register fields 0.
- Destination: `dest = regdst ? rd : rt`, computed from EX contents and captured into MEM.
- Load-use hazard: `hz = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (ex_rt == id_rt))`.
- Branch taken: `pc_src = (mem_branch & mem_zero) | (mem_bne & ~mem_zero)`.
- Combinational outputs:
  - `flush_ifid = pc_src`.
  - `stall = hz & ~pc_src`; flush has priority over stall.
- Next state per edge:
  - pc_src=1: EX and MEM load bubble; WB loads MEM normally.
  - else stall=1: EX loads bubble; MEM and WB advance normally.
  - else: all stages advance.
- Counters:
  - `stall_cnt` increments on each cycle with stall=1.
  - `flush_cnt` increments on each cycle with pc_src=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system):
  - All stage registers are bubbles.
  - Counters are 0.
  - All outputs are 0: stall, flush_ifid and pc_src are 0 because they derive from zero state.
- Latency: an ID word appears at EX outputs 1 edge later, at MEM 2 edges later, at WB 3 edges later.
- stall and pc_src are valid in the same cycle as their causes, with no registered delay.
- A stall lasts exactly one cycle per load. After the bubble enters EX, `ex_memread` is 0, so `hz` clears.
- Reset asserted mid-operation clears all in-flight state immediately; no partial stage survives.
- The `ex_rt == 0` check is required: $zero never causes a stall.

## Structure
- Shared package `ctrl_pkg` holds:
  - Bit-index constants for the 9-bit word: `CW_MEMTOREG=8` … `CW_ALUOP_BEQ=0`.
  - `CW_W=9`.
  - The `BUBBLE` constant.
  - The packed stage-record typedefs: `ex_rec_t`, `mem_rec_t`, `wb_rec_t`.
- One natural sub-module, `hazard_unit`: combinational `hz`/`pc_src`/`stall`/`flush_ifid` logic. Stage registers and counters stay in `ctrl_pipe`.

## Test plan
- Reset pulse mid-stream with non-zero words in all stages:
  - All outputs are 0 during reset.
  - On the next edge after release, with `id_ctrl=0`, the outputs remain 0.
- R-type stream, `id_ctrl=9'b0_1_000_1010`, rd=5:
  - `ex_regdst=1` after 1 edge.
  - `mem_dest=5`, `mem_regwrite=1` after 2 edges.
  - `wb_dest=5`, `wb_regwrite=1` after 3 edges.
- lw (`9'b1_1_010_0100`, rt=8) followed by an ID instruction with rs=8:
  - `stall=1` for exactly one cycle.
  - EX shows a bubble on the next edge.
  - `stall_cnt` = 1.
- lw with rt=0, followed by an instruction with rs=0: `stall` stays 0.
- beq (`9'b0_0_100_0001`) reaches MEM with `mem_zero=1`:
  - `pc_src=1` and `flush_ifid=1` in that cycle.
  - EX and MEM are bubbles next edge; `flush_cnt` = 1.
  - The same beq with `mem_zero=0` causes no flush.
- Simultaneous load-use hazard and taken bne in MEM (`mem_zero=0`):
  - `stall=0`, `pc_src=1`.
  - Only `flush_cnt` increments.
- Force `stall_cnt` to all-ones (`CNT_W=4`: 15), then cause one more stall: the count stays at 15.
